hamming_decoder: RTL and testbench
==================================

Name: hamming_decoder

Overview:
- Receive-side SECDED decoder for the 16-bit Hamming package built by the transmitter's encoder.
- Recovers the 8-bit data word, corrects any single-bit error and flags double-bit errors.
- Two-stage pipeline with valid/ready handshakes on both sides; sits between the line deserializer and the byte consumer.

Parameters:
- CNT_W, 16, width of the saturating error counters (only used with HAMMING_ERR_CNT_EN).

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- package_i  in  16  received package.
- valid_i  in  1  package_i valid.
- ready_o  out  1  decoder can accept a package.
- data_o  out  8  decoded (corrected) data.
- corrected_o  out  1  a single error was detected and fixed.
- uncorrectable_o  out  1  a double error was detected.
- syndrome_o  out  4  raw syndrome, for debug.
- valid_o  out  1  outputs valid.
- ready_i  in  1  consumer accepts.
- clr_cnt_i  in  1  synchronous counter clear (HAMMING_ERR_CNT_EN only).
- cnt_corr_o  out  CNT_W  corrected-error count (HAMMING_ERR_CNT_EN only).
- cnt_uncorr_o  out  CNT_W  uncorrectable-error count (HAMMING_ERR_CNT_EN only).

Behaviour:
- Package format:
  - package[k], k=1..15, is Hamming position k.
  - Parity bits sit at positions 1, 2, 4, 8.
  - Data mapping: data[0]=pos3, data[3:1]=pos7:5, data[7:4]=pos12:9.
  - Positions 13..15 are transmitted as 0.
  - package[0] = even overall parity over bits 15:1.
- Stage 1 (S1) registers package_i and computes:
  - syndrome S = XOR of the indices k (1..15) with package[k]=1.
  - overall parity P = ^package[15:0].
- Stage 2 (S2) classifies:
  - S==0, P==0: clean; data extracted as-is.
  - S!=0, P==1: single error at position S.
    - If S is in 1..12, flip bit S before extraction.
    - If S is in 13..15, data is unaffected.
    - corrected_o=1.
  - S==0, P==1: error in bit 0; data unaffected; corrected_o=1.
  - S!=0, P==0: double error; uncorrectable_o=1; data_o = uncorrected extraction.
- corrected_o and uncorrectable_o are never both 1.
- Handshake:
  - A transfer occurs on valid&ready on each side.
  - advance = !s2_valid | ready_i.
  - ready_o = !s1_valid | advance.
  - Full throughput: one package per clock when ready_i=1.
  - Latency is 2 clocks from input transfer to valid_o.
- Outputs are held stable while valid_o=1 and ready_i=0.
- Data never changes except on an accepted transfer.
- No package is dropped or duplicated under any valid_i/ready_i pattern.
- Reset (synchronous, mid-operation included):
  - Clears both pipeline valids.
  - valid_o=0, data_o=0, corrected_o=0, uncorrectable_o=0, syndrome_o=0, counters=0.
  - ready_o=1 in the first cycle after reset.
- Simultaneous input acceptance and output drain in one cycle is allowed and must not lose data.

Optional Feature:
- HAMMING_ERR_CNT_EN defined:
  - cnt_corr_o / cnt_uncorr_o increment by 1 on each output transfer (valid_o&ready_i) whose corrected_o / uncorrectable_o is 1.
  - Counters saturate at all-ones.
  - clr_cnt_i zeroes both counters; clear wins over a same-cycle increment.
- HAMMING_ERR_CNT_EN undefined: counter ports and clr_cnt_i are absent; no counter logic.

Decomposition:
- Package hamming_pkg holds:
  - PKG_W=16 and DATA_W=8.
  - Data-position constants (3,5,6,7,9,10,11,12) and parity positions (1,2,4,8).
  - Enum err_class_t {ERR_NONE, ERR_CORR, ERR_UNCORR}.
- One sub-module, hamming_syndrome: combinational S and P from 16 bits; reusable by the encoder testbench.

Test Plan:
- data 0xA5 encodes to package 0x144E; inject 0x144E with ready_i=1 -> 2 clocks later data_o=0xA5, corrected_o=0, uncorrectable_o=0, syndrome_o=0.
- Single errors:
  - 0x146E (bit5 flipped) -> data_o=0xA5, corrected_o=1, syndrome_o=5.
  - 0x144F (bit0 flipped) -> data_o=0xA5, corrected_o=1, syndrome_o=0.
- 0x166E (bits 5 and 9 flipped) -> uncorrectable_o=1, corrected_o=0, syndrome_o=12, data_o=0xB7.
- Back-to-back stream of 8 packages with ready_i toggling 1,0,0,1,... -> all 8 outputs in order with no loss or duplication; outputs stable while stalled; ready_o low only when both stages are full and stalled.
- Assert rst_i for 1 clock with both stages full -> next cycle valid_o=0 and ready_o=1; with HAMMING_ERR_CNT_EN:
  - 3 corrected and 2 uncorrectable transfers -> cnt_corr_o=3, cnt_uncorr_o=2.
  - clr_cnt_i coincident with an error transfer -> both counters read 0.

Source files
------------

// File: rtl/hamming_pkg.sv
// hamming_pkg: shared SECDED constants, error classes and data extraction for the Hamming(16,8) package.
package hamming_pkg;
    localparam int PKG_W  = 16;
    localparam int DATA_W = 8;
    localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12};
    localparam int PAR_POS  [4]      = '{1, 2, 4, 8};

    typedef enum logic [1:0] {ERR_NONE, ERR_CORR, ERR_UNCORR} err_class_t;

    function automatic logic [DATA_W-1:0] extract_data(input logic [PKG_W-1:0] p);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W; i++) d[i] = p[DATA_POS[i]];
        return d;
    endfunction
endpackage

// File: rtl/hamming_syndrome.sv
// hamming_syndrome: combinational syndrome (XOR of set-bit indices) and overall parity of a package.
module hamming_syndrome
    import hamming_pkg::*;
(
    input  logic [PKG_W-1:0] pkg_i,
    output logic [3:0]       syndrome_o,
    output logic             parity_o
);
    // Syndrome bit i is the parity check covered by parity position PAR_POS[i].
    always_comb begin
        syndrome_o = '0;
        for (int i = 0; i < 4; i++)
            for (int k = 1; k < PKG_W; k++)
                if ((k & PAR_POS[i]) != 0) syndrome_o[i] = syndrome_o[i] ^ pkg_i[k];
        parity_o = ^pkg_i;
    end
endmodule

// File: rtl/hamming_decoder.sv
// hamming_decoder: two-stage SECDED decoder with valid/ready on both sides.
// Define HAMMING_ERR_CNT_EN to add saturating corrected/uncorrectable error counters.
module hamming_decoder
    import hamming_pkg::*;
`ifdef HAMMING_ERR_CNT_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [PKG_W-1:0]  package_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] data_o,
    output logic              corrected_o,
    output logic              uncorrectable_o,
    output logic [3:0]        syndrome_o,
    output logic              valid_o,
    input  logic              ready_i
`ifdef HAMMING_ERR_CNT_EN
    ,
    input  logic              clr_cnt_i,
    output logic [CNT_W-1:0]  cnt_corr_o,
    output logic [CNT_W-1:0]  cnt_uncorr_o
`endif
);
    logic [PKG_W-1:0]  s1_pkg_q, s1_pkg_d, flip, fixed;
    logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              corr_q, corr_d, uncorr_q, uncorr_d;
    logic [3:0]        syn_q, syn_d, syn;
    logic              par, advance, load;
    err_class_t        cls;

    hamming_syndrome u_syndrome (
        .pkg_i      (s1_pkg_q),
        .syndrome_o (syn),
        .parity_o   (par)
    );

    always_comb begin
        advance    = !s2_valid_q || ready_i;
        ready_o    = !s1_valid_q || advance;
        load       = advance && s1_valid_q;
        cls        = (syn == 4'd0 && !par) ? ERR_NONE : par ? ERR_CORR : ERR_UNCORR;
        flip       = '0;
        flip[syn]  = (cls == ERR_CORR);
        fixed      = s1_pkg_q ^ flip;
        s1_valid_d = ready_o ? valid_i : s1_valid_q;
        s1_pkg_d   = (ready_o && valid_i) ? package_i : s1_pkg_q;
        s2_valid_d = advance ? s1_valid_q : s2_valid_q;
        data_d     = load ? extract_data(fixed) : data_q;
        corr_d     = load ? (cls == ERR_CORR) : corr_q;
        uncorr_d   = load ? (cls == ERR_UNCORR) : uncorr_q;
        syn_d      = load ? syn : syn_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_pkg_q   <= '0;
            s2_valid_q <= 1'b0;
            data_q     <= '0;
            corr_q     <= 1'b0;
            uncorr_q   <= 1'b0;
            syn_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_pkg_q   <= s1_pkg_d;
            s2_valid_q <= s2_valid_d;
            data_q     <= data_d;
            corr_q     <= corr_d;
            uncorr_q   <= uncorr_d;
            syn_q      <= syn_d;
        end
    end

    assign valid_o         = s2_valid_q;
    assign data_o          = data_q;
    assign corrected_o     = corr_q;
    assign uncorrectable_o = uncorr_q;
    assign syndrome_o      = syn_q;

`ifdef HAMMING_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d, cnt_uncorr_q, cnt_uncorr_d;
    logic             xfer;

    // Clear takes priority over a coincident increment; counters stick at all-ones.
    always_comb begin
        xfer         = s2_valid_q && ready_i;
        cnt_corr_d   = clr_cnt_i ? '0 : (xfer && corr_q && !(&cnt_corr_q)) ? cnt_corr_q + CNT_W'(1) : cnt_corr_q;
        cnt_uncorr_d = clr_cnt_i ? '0 : (xfer && uncorr_q && !(&cnt_uncorr_q)) ? cnt_uncorr_q + CNT_W'(1) : cnt_uncorr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_corr_q   <= '0;
            cnt_uncorr_q <= '0;
        end else begin
            cnt_corr_q   <= cnt_corr_d;
            cnt_uncorr_q <= cnt_uncorr_d;
        end
    end

    assign cnt_corr_o   = cnt_corr_q;
    assign cnt_uncorr_o = cnt_uncorr_q;
`endif
endmodule

// File: tb/tb_hamming_decoder.sv
// tb_hamming_decoder: vector table, handshake stream and random checks against a behavioural SECDED model.
module tb_hamming_decoder;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] package_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [7:0]  data_o;
    logic        corrected_o, uncorrectable_o, valid_o;
    logic [3:0]  syndrome_o;
    logic        ready_i = 1'b0;
    logic        clr_cnt_i = 1'b0;
    logic [15:0] cnt_corr_o, cnt_uncorr_o;

    hamming_decoder dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .package_i       (package_i),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .data_o          (data_o),
        .corrected_o     (corrected_o),
        .uncorrectable_o (uncorrectable_o),
        .syndrome_o      (syndrome_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i)
`ifdef HAMMING_ERR_CNT_EN
        ,
        .clr_cnt_i       (clr_cnt_i),
        .cnt_corr_o      (cnt_corr_o),
        .cnt_uncorr_o    (cnt_uncorr_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] d;
        logic       c;
        logic       u;
        logic [3:0] s;
    } res_t;

    typedef struct {
        logic [15:0] pkg;
        res_t        exp;
    } vec_t;

    int   n_cmp = 0, n_bad = 0;
    res_t exp_q[$];
    logic stall_prev = 1'b0;
    res_t held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: syndrome as XOR of set-bit indices, parity by popcount.
    function automatic res_t model(input logic [15:0] p);
        res_t        r;
        logic [3:0]  s = '0;
        logic        par = 1'b0;
        logic [15:0] q = p;
        for (int k = 0; k < 16; k++)
            if (p[k]) begin
                par = ~par;
                s   = s ^ 4'(k);
            end
        if (par && s != 0) q[s] = ~q[s];
        r.d = {q[12:9], q[7:5], q[3]};
        r.c = par;
        r.u = !par && s != 0;
        r.s = s;
        return r;
    endfunction

    function automatic logic [15:0] encode(input logic [7:0] d);
        logic [15:0] p = '0;
        logic [3:0]  s = '0;
        p[3] = d[0]; p[7:5] = d[3:1]; p[12:9] = d[7:4];
        for (int k = 1; k < 16; k++) if (p[k]) s = s ^ 4'(k);
        p[1] = s[0]; p[2] = s[1]; p[4] = s[2]; p[8] = s[3];
        p[0] = ^p;
        return p;
    endfunction

    task automatic cmp_res(input string tag, input res_t e);
        chk({tag, "_data"}, 32'(data_o), 32'(e.d));
        chk({tag, "_corr"}, 32'(corrected_o), 32'(e.c));
        chk({tag, "_uncorr"}, 32'(uncorrectable_o), 32'(e.u));
        chk({tag, "_syn"}, 32'(syndrome_o), 32'(e.s));
    endtask

    // One clock of stimulus with scoreboard, occupancy-based ready_o and stall-stability checks.
    task automatic step(input logic v, input logic [15:0] p, input logic r, input logic clr);
        res_t e;
        @(negedge clk_i);
        valid_i = v; package_i = p; ready_i = r; clr_cnt_i = clr;
        #1;
        chk("ready_o", 32'(ready_o), 32'(!(exp_q.size() == 2 && !r)));
        if (stall_prev) begin
            chk("stall_valid", 32'(valid_o), 32'd1);
            cmp_res("stall", held);
        end
        if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL dup: output transfer with nothing outstanding, data %0h", data_o);
            end else begin
                e = exp_q.pop_front();
                cmp_res("stream", e);
            end
        end
        if (v && ready_o) exp_q.push_back(model(p));
        stall_prev = valid_o && !ready_i;
        held = '{d: data_o, c: corrected_o, u: uncorrectable_o, s: syndrome_o};
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk_i);
        package_i = v.pkg; valid_i = 1'b1; ready_i = 1'b1;
        #1 chk("vec_ready", 32'(ready_o), 32'd1);
        @(negedge clk_i);
        valid_i = 1'b0;
        chk("vec_lat1_valid", 32'(valid_o), 32'd0);
        @(negedge clk_i);
        chk("vec_lat2_valid", 32'(valid_o), 32'd1);
        cmp_res("vec", v.exp);
        chk("vec_excl", 32'(corrected_o & uncorrectable_o), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{16'h144E, '{8'hA5, 1'b0, 1'b0, 4'd0}};
        vecs[1] = '{16'h146E, '{8'hA5, 1'b1, 1'b0, 4'd5}};
        vecs[2] = '{16'h144F, '{8'hA5, 1'b1, 1'b0, 4'd0}};
        vecs[3] = '{16'h166E, '{8'hB7, 1'b0, 1'b1, 4'd12}};
        vecs[4] = '{16'h544E, '{8'hA5, 1'b1, 1'b0, 4'd14}};
        vecs[5] = '{16'h0000, '{8'h00, 1'b0, 1'b0, 4'd0}};

        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_ready_o", 32'(ready_o), 32'd1);
        cmp_res("rst", '{8'h00, 1'b0, 1'b0, 4'd0});

        foreach (vecs[i]) run_vec(vecs[i]);
        step(1'b0, 16'h0, 1'b1, 1'b0);

        // Back-to-back stream with consumer pattern 1,0,0,...
        for (int i = 0; i < 8; i++) step(1'b1, encode(8'(i * 37 + 5)) ^ (i % 2 ? 16'h0020 : 16'h0), (i % 3) == 0, 1'b0);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) step(1'b0, 16'h0, (i % 3) == 0, 1'b0);
        drain();

        for (int i = 0; i < 300; i++) begin
            logic [15:0] p = encode(8'($urandom));
            int nf = $urandom_range(0, 2);
            int a = $urandom_range(0, 15);
            int b = (a + $urandom_range(1, 15)) % 16;
            if (nf >= 1) p[a] = ~p[a];
            if (nf == 2) p[b] = ~p[b];
            step($urandom_range(0, 3) != 0, p, $urandom_range(0, 2) != 0, 1'b0);
        end
        drain();

        // Fill both stages, then reset mid-operation.
        step(1'b1, 16'h166E, 1'b0, 1'b0);
        step(1'b1, 16'h146E, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("midrst_valid_o", 32'(valid_o), 32'd0);
        chk("midrst_ready_o", 32'(ready_o), 32'd1);
        cmp_res("midrst", '{8'h00, 1'b0, 1'b0, 4'd0});
        exp_q.delete();
        stall_prev = 1'b0;

`ifdef HAMMING_ERR_CNT_EN
        chk("cnt_corr_rst", 32'(cnt_corr_o), 32'd0);
        chk("cnt_uncorr_rst", 32'(cnt_uncorr_o), 32'd0);
        step(1'b1, 16'h146E, 1'b1, 1'b0);
        step(1'b1, 16'h166E, 1'b1, 1'b0);
        step(1'b1, 16'h144F, 1'b1, 1'b0);
        step(1'b1, 16'h144E, 1'b1, 1'b0);
        step(1'b1, 16'h166E, 1'b1, 1'b0);
        step(1'b1, 16'h544E, 1'b1, 1'b0);
        drain();
        chk("cnt_corr_3", 32'(cnt_corr_o), 32'd3);
        chk("cnt_uncorr_2", 32'(cnt_uncorr_o), 32'd2);
        step(1'b1, 16'h146E, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("pre_clr_corr_held", 32'(valid_o & corrected_o), 32'd1);
        step(1'b0, 16'h0, 1'b1, 1'b1);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("cnt_corr_clr", 32'(cnt_corr_o), 32'd0);
        chk("cnt_uncorr_clr", 32'(cnt_uncorr_o), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
